// File: rtl/cpu_io_responder.sv
// CPU OUT/IN port responder: TX FIFO drained to a valid/ready sink, RX FIFO filled from a valid/ready source.
// Optional IO_LOOPBACK_EN adds a loopback input that routes the TX head straight into RX.
module cpu_io_responder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IO_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic [31:0]       cpu_out_data,
    input  logic              cpu_out_we,
    output logic [31:0]       cpu_in_data,
    input  logic              cpu_in_re,
    output logic              cpu_in_avail,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W:0]   tx_level,
    output logic [ADDR_W:0]   rx_level,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    input  logic              clr_sticky
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [7:0]        tx_mem_q [DEPTH];
    logic [7:0]        rx_mem_q [DEPTH];

    logic [ADDR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [ADDR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [ADDR_W:0]   tx_level_q, tx_level_d, rx_level_q, rx_level_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    logic              lb_en, lb_move;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]        tx_head, rx_head, rx_wdata;
    logic              unused_out_bits;

`ifdef IO_LOOPBACK_EN
    assign lb_en = loopback;
`else
    assign lb_en = 1'b0;
`endif

    assign unused_out_bits = ^cpu_out_data[31:8];

    always_comb begin
        tx_empty = (tx_level_q == '0);
        tx_full  = (tx_level_q == LVL_FULL);
        rx_empty = (rx_level_q == '0);
        rx_full  = (rx_level_q == LVL_FULL);
        tx_head  = tx_mem_q[tx_rptr_q];
        rx_head  = rx_mem_q[rx_rptr_q];

        // In loopback the external handshakes are masked and the TX head moves to RX internally.
        lb_move  = lb_en & ~tx_empty & ~rx_full;
        tx_valid = ~lb_en & ~tx_empty;
        rx_ready = ~lb_en & ~rx_full;

        tx_push  = cpu_out_we & ~tx_full;
        tx_pop   = lb_move | (tx_valid & tx_ready);
        rx_push  = lb_move | (rx_valid & rx_ready);
        rx_pop   = cpu_in_re & ~rx_empty;
        rx_wdata = lb_en ? tx_head : rx_data;

        tx_data      = tx_empty ? 8'h00 : tx_head;
        cpu_in_data  = {24'h000000, (rx_empty ? 8'h00 : rx_head)};
        cpu_in_avail = ~rx_empty;
        tx_level     = tx_level_q;
        rx_level     = rx_level_q;
        ovf_sticky   = ovf_q;
        unf_sticky   = unf_q;
    end

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_level_d = tx_level_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_level_d = rx_level_q;

        if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
        if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + LVL_ONE;
            2'b01:   tx_level_d = tx_level_q - LVL_ONE;
            default: tx_level_d = tx_level_q;
        endcase

        if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
        if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + LVL_ONE;
            2'b01:   rx_level_d = rx_level_q - LVL_ONE;
            default: rx_level_d = rx_level_q;
        endcase

        // A new event wins over a coincident clear.
        ovf_d = (cpu_out_we & tx_full)  | (ovf_q & ~clr_sticky);
        unf_d = (cpu_in_re  & rx_empty) | (unf_q & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left unreset; the levels gate every read.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= cpu_out_data[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_wdata;
    end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Scoreboard bench for cpu_io_responder: stimulus queues expected bytes, a negedge monitor checks them.
module tb_cpu_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_out_data = '0;
    logic        cpu_out_we = 1'b0;
    logic [31:0] cpu_in_data;
    logic        cpu_in_re = 1'b0;
    logic        cpu_in_avail;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [4:0]  tx_level, rx_level;
    logic        ovf_sticky, unf_sticky;
    logic        clr_sticky = 1'b0;
`ifdef IO_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [31:0] tx_q [$];
    logic [31:0] rx_q [$];

    always #5 clk = ~clk;

    cpu_io_responder #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst),
`ifdef IO_LOOPBACK_EN
        .loopback(loopback),
`endif
        .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
        .cpu_in_data(cpu_in_data), .cpu_in_re(cpu_in_re), .cpu_in_avail(cpu_in_avail),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .clr_sticky(clr_sticky)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_out(input logic [31:0] d);
        cpu_out_data = d;
        cpu_out_we   = 1'b1;
        tick();
        cpu_out_we   = 1'b0;
    endtask

    task automatic cpu_in(input logic [31:0] exp);
        rx_q.push_back(exp);
        cpu_in_re = 1'b1;
        tick();
        cpu_in_re = 1'b0;
        tick();
    endtask

    // Monitor: compares whenever the DUT presents a byte on either side.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no transfer", tx_data);
                end else check("tx_data", 32'(tx_data), tx_q.pop_front());
            end
            if (cpu_in_re) begin
                if (rx_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no read", cpu_in_data);
                end else check("cpu_in_data", cpu_in_data, rx_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_rx_ready", 32'(rx_ready), 1);
        check("rst_avail", 32'(cpu_in_avail), 0);
        check("rst_tx_level", 32'(tx_level), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        // Single OUT, held while the sink stalls
        cpu_out(32'h1234_56A5);
        check("out_tx_valid", 32'(tx_valid), 1);
        check("out_tx_data", 32'(tx_data), 32'hA5);
        check("out_tx_level", 32'(tx_level), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("out_tx_stable", 32'(tx_data), 32'hA5);
        end
        tx_q.push_back(32'hA5);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("out_tx_level_drained", 32'(tx_level), 0);
        check("out_tx_valid_drained", 32'(tx_valid), 0);

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) tx_q.push_back(32'(i));
            cpu_out(32'(i));
        end
        check("ovf_level", 32'(tx_level), 16);
        check("ovf_sticky", 32'(ovf_sticky), 1);
        check("ovf_head", 32'(tx_data), 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_cleared", 32'(ovf_sticky), 0);
        // Write while full with a pop in the same cycle is still dropped
        cpu_out_data = 32'hEE;
        cpu_out_we   = 1'b1;
        tx_ready     = 1'b1;
        tick();
        cpu_out_we   = 1'b0;
        tx_ready     = 1'b0;
        check("ovf_pop_level", 32'(tx_level), 15);
        check("ovf_pop_sticky", 32'(ovf_sticky), 1);
        tx_ready = 1'b1;
        repeat (17) tick();
        tx_ready = 1'b0;
        check("ovf_drain_level", 32'(tx_level), 0);
        check("ovf_drain_queue", 32'(tx_q.size()), 0);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;

        // Simultaneous push and pop keeps the level
        tx_q.push_back(32'h11);
        cpu_out(32'h11);
        tx_q.push_back(32'h22);
        cpu_out_data = 32'hFFFF_FF22;
        cpu_out_we   = 1'b1;
        tx_ready     = 1'b1;
        tick();
        cpu_out_we   = 1'b0;
        tx_ready     = 1'b0;
        check("pp_tx_level", 32'(tx_level), 1);
        check("pp_tx_data", 32'(tx_data), 32'h22);
        tx_ready = 1'b1;
        repeat (2) tick();
        tx_ready = 1'b0;
        check("pp_tx_level_end", 32'(tx_level), 0);

        // RX path and underflow
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        tick();
        rx_data  = 8'h7E;
        tick();
        rx_valid = 1'b0;
        check("rx_level2", 32'(rx_level), 2);
        check("rx_avail", 32'(cpu_in_avail), 1);
        check("rx_head", cpu_in_data, 32'h3C);
        cpu_in(32'h3C);
        cpu_in(32'h7E);
        cpu_in(32'h0);
        check("unf_sticky", 32'(unf_sticky), 1);
        check("unf_avail", 32'(cpu_in_avail), 0);

        // Clear coincident with a new underflow: set wins
        rx_q.push_back(32'h0);
        clr_sticky = 1'b1;
        cpu_in_re  = 1'b1;
        tick();
        clr_sticky = 1'b0;
        cpu_in_re  = 1'b0;
        check("unf_set_beats_clr", 32'(unf_sticky), 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("unf_clr_alone", 32'(unf_sticky), 0);

        // Underflow read with a push in the same cycle still accepts the push
        rx_q.push_back(32'h0);
        cpu_in_re = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h9A;
        tick();
        cpu_in_re = 1'b0;
        rx_valid  = 1'b0;
        check("unf_push_level", 32'(rx_level), 1);
        check("unf_push_sticky", 32'(unf_sticky), 1);
        tick();
        cpu_in(32'h9A);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;

        // RX fill to full; the 17th offer is refused
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h40 + i);
            tick();
        end
        rx_valid = 1'b0;
        check("rx_full_level", 32'(rx_level), 16);
        check("rx_full_ready", 32'(rx_ready), 0);
        for (int i = 0; i < 16; i++) cpu_in(32'(8'h40 + i));
        check("rx_empty_level", 32'(rx_level), 0);
        check("rx_empty_ready", 32'(rx_ready), 1);

`ifdef IO_LOOPBACK_EN
        loopback = 1'b1;
        cpu_out(32'h55);
        check("lb_tx_valid", 32'(tx_valid), 0);
        tick();
        check("lb_rx_level", 32'(rx_level), 1);
        check("lb_data", cpu_in_data, 32'h55);
        check("lb_tx_valid2", 32'(tx_valid), 0);
        cpu_in(32'h55);
        loopback = 1'b0;
`endif

        // Async reset mid-transfer discards everything
        cpu_in(32'h0);
        cpu_out(32'hA1);
        cpu_out(32'hA2);
        cpu_out(32'hA3);
        rx_valid = 1'b1;
        rx_data  = 8'hB1;
        tick();
        rx_data  = 8'hB2;
        tick();
        rx_valid = 1'b0;
        check("pre_rst_tx_level", 32'(tx_level), 3);
        check("pre_rst_rx_level", 32'(rx_level), 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tx_level", 32'(tx_level), 0);
        check("arst_rx_level", 32'(rx_level), 0);
        check("arst_tx_valid", 32'(tx_valid), 0);
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_avail", 32'(cpu_in_avail), 0);
        check("arst_in_data", cpu_in_data, 0);
        check("arst_rx_ready", 32'(rx_ready), 1);
        check("arst_unf", 32'(unf_sticky), 0);
        tx_q.delete();
        rx_q.delete();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_tx_valid", 32'(tx_valid), 0);

        check("end_tx_queue", 32'(tx_q.size()), 0);
        check("end_rx_queue", 32'(rx_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
